// File: rtl/tt_capture.sv
// Sequential truth-table extractor: sweeps x over every pattern and records f_in into tt.
// Optional TT_CAPTURE_COMPARE_EN adds exp_tt and reports match / first mismatching index.
module tt_capture #(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   f_in,
    output logic [N_IN-1:0]        x,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   tt,
`ifdef TT_CAPTURE_COMPARE_EN
    output logic [N_IN:0]          ones,
    input  logic [(1<<N_IN)-1:0]   exp_tt,
    output logic                   match,
    output logic [N_IN-1:0]        first_err
`else
    output logic [N_IN:0]          ones
`endif
);

    localparam int              TT_W       = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(TT_W - 1);
    localparam logic [3:0]      SETTLE_END = 4'(SETTLE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [3:0]      settle_cnt;

    // Each pattern is held SETTLE+1 cycles; f_in is only looked at on the last of them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tt         <= '0;
            ones       <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
            match      <= 1'b1;
            first_err  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        x          <= '0;
                        idx        <= '0;
                        settle_cnt <= '0;
                        tt         <= '0;
                        ones       <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
                        match      <= 1'b1;
                        first_err  <= '0;
`endif
                    end
                end
                RUN: begin
                    if (settle_cnt == SETTLE_END) begin
                        tt[idx] <= f_in;
                        ones    <= ones + {{N_IN{1'b0}}, f_in};
`ifdef TT_CAPTURE_COMPARE_EN
                        // match still high means this is the first mismatch, so its index is the lowest
                        if (f_in != exp_tt[idx]) begin
                            match <= 1'b0;
                            if (match)
                                first_err <= idx;
                        end
`endif
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            x     <= '0;
                            idx   <= '0;
                        end else begin
                            idx        <= idx + 1'b1;
                            x          <= idx + 1'b1;
                            settle_cnt <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
